lcd1602_bus_responder: RTL
==========================

// Module: lcd1602_bus_responder
// PURPOSE
//  HD44780-compatible responder for the 8-bit LCD1602 parallel bus: the display end of the link our LCD driver masters.
//  Samples LCD_E/RS/RW/DATA, decodes instructions, keeps the 80-byte DDRAM, address counter (AC) and mode bits.
//  Answers busy-flag/AC and DDRAM-data reads. Serves as on-FPGA LCD emulator and as a loop-back checker for the driver.
// PARAMETERS
//  SYNC_STAGES   2      flops per bus input (E, RS, RW, DATA[7:0]) before use.
//  BUSY_CYCLES   1850   clk cycles busy after a normal instruction or data write (37 us at 50 MHz).
//  CLEAR_CYCLES  82000  clk cycles busy after Clear/Return-home (1.64 ms); must be >= 80.
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset, synchronous, active-high
//  lcd_e         in   1   bus enable, asynchronous to clk
//  lcd_rs        in   1   0 = instruction/status, 1 = data
//  lcd_rw        in   1   0 = write, 1 = read
//  lcd_data_in   in   8   bus data from initiator
//  lcd_data_out  out  8   read data to bus
//  lcd_data_oe   out  1   1 = responder drives the bus (tristate at top level)
//  view_addr     in   7   host-side DDRAM index 0..79 (0..39 = line 1, 40..79 = line 2)
//  view_data     out  8   DDRAM[view_addr], registered, 1-cycle latency
//  status        out  16  {disp_on,cursor_on,blink_on,id_inc,shift_en,two_line,font_5x10,busy,ac[6:0],cg_mode}
//  disp_shift    out  6   display shift offset 0..39
//  cmd_strobe    out  1   1-cycle pulse per accepted write (instruction or data)
//  err_flag      out  1   sticky; set by any error below; cleared only by rst
// BEHAVIOUR
//  Reset: DDRAM filled with 0x20 (80-cycle fill, busy=1 meanwhile); ac=0; id_inc=1; all other status bits 0.
//   disp_shift=0, lcd_data_oe=0, lcd_data_out=0, cmd_strobe=0, err_flag=0.
//  Sampling: a write is taken on the synchronized E falling edge, using RS/RW/DATA from the same sync stage.
//   Decode in the next cycle; result (DDRAM/AC/status) visible 2 cycles after the edge. cmd_strobe fires in the decode cycle.
//  Reads: while synced E=1 and RW=1: lcd_data_oe=1.
//   RS=0 -> lcd_data_out={busy,ac}. RS=1 -> DDRAM[ac], then AC steps by I/D on E fall (no shift).
//   oe drops the cycle after synced E falls.
//  FSM: IDLE -> DECODE (on E fall) -> EXEC -> BUSY_WAIT -> IDLE.
//   Clear: DECODE -> CLEAR_FILL (80 cycles writing 0x20) -> BUSY_WAIT. Busy counter loads BUSY_CYCLES or CLEAR_CYCLES in EXEC.
//  Instructions (highest set bit wins):
//   0x01 Clear: fill, ac=0, id_inc=1, disp_shift=0.
//   0x02/03 Return home: ac=0, disp_shift=0.
//   0000_01IS entry mode.
//   0000_1DCB display control.
//   0001_SR__ S=1: disp_shift +/-1 mod 40. S=0: AC +/-1 with wrap.
//   001D_NF__ function set; D=0 (4-bit) -> err_flag, bits still recorded.
//   01xx_xxxx Set CGRAM: cg_mode=1.
//   1aaa_aaaa Set DDRAM: cg_mode=0, ac=a.
//  Data write: if cg_mode, discard (AC unchanged). Else write DDRAM[ac], step AC by I/D; if shift_en, disp_shift steps opposite (mod 40).
//  AC map/wrap: valid 0x00-0x27 and 0x40-0x67. Increments 0x27->0x40 and 0x67->0x00; decrements 0x00->0x67 and 0x40->0x27.
//  Set DDRAM with a=0x28-0x3F or 0x68-0x7F: ignored, ac kept, err_flag set.
//  Write accepted while busy=1: ignored, no cmd_strobe, err_flag set. Reads while busy are always served.
//  rst mid-fill or mid-busy: immediate return to the reset sequence; no partial state survives.
// CONFIGURATION
//  LCD_BUSY_MODEL_EN defined: busy timing as above.
//  Not defined: BUSY_WAIT bypassed; busy=1 only during CLEAR_FILL; writes during fill are still errors.
// STRUCTURE
//  Package lcd1602_pkg: instruction opcodes/masks, line base addresses 0x00/0x40, line length 40, DDRAM depth 80, FSM state enum.
//  Sub-module lcd1602_ddram: 80x8 RAM, 1 sync write port, 2 registered read ports (bus read, view port).
// TESTING
//  Reset, wait 100 cycles; view all 80 -> 0x20, status ac=0, id_inc=1.
//  Write 0x38,0x0F,0x06,0x80, then 'A'(0x41) -> DDRAM[0]=0x41; ac=0x01; two_line=1; disp_on/cursor_on/blink_on=1.
//  Set 0xA7 (ac=0x27), write 0x5A -> view[39]=0x5A, ac=0x40; entry 0x04 at ac=0x40, data -> ac=0x27.
//  Instruction read (RS=0,RW=1) right after a write -> 0x80|ac while busy, then {0,ac} after BUSY_CYCLES; oe only while E high.
//  Write during busy, and Set DDRAM 0xB0 -> both ignored; err_flag=1; ac unchanged.
//  0x01 mid-sequence, reset asserted at fill cycle 40 -> fill restarts; all 0x20, ac=0; cmd_strobe count matches writes.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared constants, bus sample record and address helpers for the LCD1602 bus responder.
package lcd1602_pkg;

  localparam int DDRAM_DEPTH = 80;
  localparam int LINE_LEN    = 40;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);
  localparam logic [7:0] FILL_CHAR  = 8'h20;

  // Instruction class masks; the highest set bit selects the instruction.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_EXEC       = 3'd2;
  localparam logic [2:0] ST_BUSY_WAIT  = 3'd3;
  localparam logic [2:0] ST_CLEAR_FILL = 3'd4;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_t;

  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= LINE1_LAST) || (a >= LINE2_BASE && a <= LINE2_LAST);
  endfunction

  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    return (a >= LINE2_BASE) ? a - LINE2_BASE + 7'(LINE_LEN) : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE1_LAST) return LINE2_BASE;
      if (a == LINE2_LAST) return LINE1_BASE;
      return a + 7'd1;
    end
    if (a == LINE1_BASE) return LINE2_LAST;
    if (a == LINE2_BASE) return LINE1_LAST;
    return a - 7'd1;
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic inc);
    if (inc) return (s == 6'(LINE_LEN - 1)) ? 6'd0 : s + 6'd1;
    return (s == 6'd0) ? 6'(LINE_LEN - 1) : s - 6'd1;
  endfunction

endpackage

// File: rtl/lcd1602_ddram.sv
// 80x8 display RAM: one synchronous write port, registered bus and view read ports.
module lcd1602_ddram import lcd1602_pkg::*; (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [6:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we && waddr < 7'(DDRAM_DEPTH)) mem[waddr] <= wdata;
    rdata_a <= (raddr_a < 7'(DDRAM_DEPTH)) ? mem[raddr_a] : 8'h00;
    rdata_b <= (raddr_b < 7'(DDRAM_DEPTH)) ? mem[raddr_b] : 8'h00;
  end

endmodule

// File: rtl/lcd1602_bus_responder.sv
// HD44780-style responder for the 8-bit LCD1602 bus. Define LCD_BUSY_MODEL_EN to keep
// busy asserted for the instruction execution time; otherwise busy covers only the RAM fill.
module lcd1602_bus_responder import lcd1602_pkg::*; #(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_e,
  input  logic        lcd_rs,
  input  logic        lcd_rw,
  input  logic [7:0]  lcd_data_in,
  output logic [7:0]  lcd_data_out,
  output logic        lcd_data_oe,
  input  logic [6:0]  view_addr,
  output logic [7:0]  view_data,
  output logic [15:0] status,
  output logic [5:0]  disp_shift,
  output logic        cmd_strobe,
  output logic        err_flag
);

  localparam int CW = $clog2((CLEAR_CYCLES > BUSY_CYCLES ? CLEAR_CYCLES : BUSY_CYCLES) + 1);

  bus_t [SYNC_STAGES-1:0] sync_q;
  bus_t          bus_s;
  logic          e_prev, e_fall, wr_evt, rd_step, busy;
  logic          cmd_rs;
  logic [7:0]    cmd_data;
  logic [2:0]    state;
  logic [6:0]    fill_cnt, ac, ac_idx;
  logic [CW-1:0] busy_cnt;
  logic          disp_on, cursor_on, blink_on, id_inc, shift_en, two_line, font_5x10, cg_mode;
  logic          ram_we;
  logic [6:0]    ram_waddr;
  logic [7:0]    ram_wdata, ram_rd;

  assign bus_s   = sync_q[SYNC_STAGES-1];
  assign e_fall  = e_prev & ~bus_s.e;
  assign wr_evt  = e_fall & ~bus_s.rw;
  assign rd_step = e_fall & bus_s.rw & bus_s.rs;
  assign ac_idx  = ddram_idx(ac);

`ifdef LCD_BUSY_MODEL_EN
  assign busy = (state != ST_IDLE);
`else
  assign busy = (state == ST_CLEAR_FILL);
`endif

  assign status = {disp_on, cursor_on, blink_on, id_inc, shift_en, two_line, font_5x10,
                   busy, ac, cg_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      e_prev <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev <= bus_s.e;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ac_idx;
    ram_wdata = cmd_data;
    if (state == ST_CLEAR_FILL) begin
      ram_we    = 1'b1;
      ram_waddr = fill_cnt;
      ram_wdata = FILL_CHAR;
    end else if (state == ST_DECODE && cmd_rs && !cg_mode) begin
      ram_we = 1'b1;
    end
  end

  lcd1602_ddram u_ddram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (ac_idx),
    .rdata_a (ram_rd),
    .raddr_b (view_addr),
    .rdata_b (view_data)
  );

  // Reset enters the fill directly, so a reset mid-fill simply restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR_FILL;
      fill_cnt   <= '0;
      busy_cnt   <= CW'(DDRAM_DEPTH);
      cmd_rs     <= 1'b0;
      cmd_data   <= '0;
      ac         <= LINE1_BASE;
      id_inc     <= 1'b1;
      {disp_on, cursor_on, blink_on, shift_en, two_line, font_5x10, cg_mode} <= '0;
      disp_shift <= '0;
      cmd_strobe <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      if (wr_evt) begin
        if (state == ST_IDLE) begin
          cmd_rs     <= bus_s.rs;
          cmd_data   <= bus_s.data;
          cmd_strobe <= 1'b1;
          state      <= ST_DECODE;
        end else begin
          err_flag <= 1'b1;
        end
      end
      if (rd_step) ac <= ac_step(ac, id_inc);
      case (state)
        ST_DECODE: begin
          state <= ST_EXEC;
          if (cmd_rs) begin
            if (!cg_mode) begin
              ac <= ac_step(ac, id_inc);
              if (shift_en) disp_shift <= shift_step(disp_shift, !id_inc);
            end
          end else if (|(cmd_data & OP_DDRAM)) begin
            if (ac_valid(cmd_data[6:0])) begin
              ac      <= cmd_data[6:0];
              cg_mode <= 1'b0;
            end else begin
              err_flag <= 1'b1;
            end
          end else if (|(cmd_data & OP_CGRAM)) begin
            cg_mode <= 1'b1;
          end else if (|(cmd_data & OP_FUNC)) begin
            two_line  <= cmd_data[3];
            font_5x10 <= cmd_data[2];
            if (!cmd_data[4]) err_flag <= 1'b1;
          end else if (|(cmd_data & OP_SHIFT)) begin
            if (cmd_data[3]) disp_shift <= shift_step(disp_shift, cmd_data[2]);
            else             ac         <= ac_step(ac, cmd_data[2]);
          end else if (|(cmd_data & OP_DISPLAY)) begin
            {disp_on, cursor_on, blink_on} <= cmd_data[2:0];
          end else if (|(cmd_data & OP_ENTRY)) begin
            {id_inc, shift_en} <= cmd_data[1:0];
          end else if (|(cmd_data & OP_HOME)) begin
            ac         <= LINE1_BASE;
            disp_shift <= '0;
          end else if (|(cmd_data & OP_CLEAR)) begin
            ac         <= LINE1_BASE;
            id_inc     <= 1'b1;
            disp_shift <= '0;
            fill_cnt   <= '0;
            busy_cnt   <= CW'(CLEAR_CYCLES);
            state      <= ST_CLEAR_FILL;
          end
        end
        ST_EXEC: begin
          busy_cnt <= CW'(BUSY_CYCLES);
`ifdef LCD_BUSY_MODEL_EN
          state <= ST_BUSY_WAIT;
`else
          state <= ST_IDLE;
`endif
        end
        ST_CLEAR_FILL: begin
          fill_cnt <= fill_cnt + 7'd1;
          if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);
          if (fill_cnt == 7'(DDRAM_DEPTH - 1)) begin
`ifdef LCD_BUSY_MODEL_EN
            state <= ST_BUSY_WAIT;
`else
            state <= ST_IDLE;
`endif
          end
        end
        ST_BUSY_WAIT: begin
          if (busy_cnt <= CW'(1)) state <= ST_IDLE;
          else                    busy_cnt <= busy_cnt - CW'(1);
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data_oe  <= 1'b0;
      lcd_data_out <= '0;
    end else begin
      lcd_data_oe  <= bus_s.e & bus_s.rw;
      lcd_data_out <= (bus_s.e & bus_s.rw) ? (bus_s.rs ? ram_rd : {busy, ac}) : 8'h00;
    end
  end

endmodule
